// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher: iterative key expansion into an 11-entry round-key
// table, then one decryption round per clock (FIPS-197 5.3 ordering).
module aes_inv_cipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic         key_rdy,
  output logic         busy,
  output logic         done,
  output logic [127:0] text_out
);

  // state   | meaning
  // ST_IDLE | waiting; accepts ld once key_rdy is set
  // ST_KEXP | computing rk1..rk10, one per clock
  // ST_DEC  | decrypting; rnd counts the pending round key down to 0
  typedef enum logic [1:0] {ST_IDLE, ST_KEXP, ST_DEC} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [10:0] base;
    base = 11'd2047 - {a, 3'b000};
    return SBOX[base -: 8];
  endfunction

  function automatic logic [7:0] isbox_f(input logic [7:0] a);
    logic [10:0] base;
    base = 11'd2047 - {a, 3'b000};
    return INV_SBOX[base -: 8];
  endfunction

  // Multiply by a constant whose bits select a, 2a, 4a, 8a (covers 09/0b/0d/0e).
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  state_t       state, state_next;
  logic [127:0] rk [0:10];
  logic [127:0] kw, kw_next, st, st_next, rnd_out;
  logic [31:0]  ks_t, n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [3:0]   kcnt, rnd;
  logic         load_key, exp_step, accept, dec_step;

  assign busy = (state == ST_DEC);

  // kw holds the most recent round key; rcon tracks its round constant.
  assign ks_t = {sbox_f(kw[23:16]), sbox_f(kw[15:8]), sbox_f(kw[7:0]), sbox_f(kw[31:24])}
                ^ {rcon, 24'h000000};
  assign n0 = kw[127:96] ^ ks_t;
  assign n1 = kw[95:64] ^ n0;
  assign n2 = kw[63:32] ^ n1;
  assign n3 = kw[31:0] ^ n2;
  assign kw_next = {n0, n1, n2, n3};

  // rnd_out doubles as the final plaintext when rnd reaches 0.
  always_comb begin
    rnd_out = '0;
    st_next = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rnd_out[127 - 8*(r + 4*c) -: 8] = isbox_f(st[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
      end
    end
    rnd_out = rnd_out ^ rk[rnd];
    for (int c = 0; c < 4; c++) begin
      st_next[127 - 32*c -: 32] = inv_mix_col(rnd_out[127 - 32*c -: 32]);
    end
  end

  always_comb begin
    state_next = state;
    load_key   = 1'b0;
    exp_step   = 1'b0;
    accept     = 1'b0;
    dec_step   = 1'b0;
    if (rst) begin
      state_next = ST_IDLE;
    end else if (kld) begin
      load_key   = 1'b1;
      state_next = ST_KEXP;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld && key_rdy) begin
            accept     = 1'b1;
            state_next = ST_DEC;
          end
        end
        ST_KEXP: begin
          exp_step = 1'b1;
          if (kcnt == 4'd1) state_next = ST_IDLE;
        end
        ST_DEC: begin
          dec_step = 1'b1;
          if (rnd == 4'd0) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      key_rdy  <= 1'b0;
      done     <= 1'b0;
      text_out <= '0;
      rnd      <= '0;
      kcnt     <= '0;
      rcon     <= 8'h00;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (load_key) begin
        kcnt    <= 4'd10;
        rcon    <= 8'h01;
        key_rdy <= 1'b0;
      end
      if (exp_step) begin
        kcnt <= kcnt - 4'd1;
        rcon <= xt(rcon);
        if (kcnt == 4'd1) key_rdy <= 1'b1;
      end
      if (accept) rnd <= 4'd9;
      if (dec_step) begin
        if (rnd == 4'd0) begin
          text_out <= rnd_out;
          done     <= 1'b1;
        end else begin
          rnd <= rnd - 4'd1;
        end
      end
    end
  end

  // Round-key table and state register carry no reset; they are rewritten before use.
  always_ff @(posedge clk) begin
    if (load_key) begin
      rk[0] <= key;
      kw    <= key;
    end
    if (exp_step) begin
      rk[4'd11 - kcnt] <= kw_next;
      kw               <= kw_next;
    end
    if (accept) st <= text_in ^ rk[10];
    if (dec_step) st <= st_next;
  end

endmodule
